// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU, one quotient bit per clock.
// Optional DIV_DBZ_FLAG_EN adds a registered div_by_zero_o flag that accompanies ready_o.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_FREE   | idle, outputs cleared, waiting for an un-annulled start
// S_BYZERO | divisor was zero, one edge to park a zero result
// S_ON     | iterating; counter counts completed quotient bits
// S_END    | result and ready held until start drops
module div_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
`ifdef DIV_DBZ_FLAG_EN
    ,
    output logic                div_by_zero_o
`endif
);

    typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   dvd_q, dvd_d;
    logic [DATA_W-1:0]   dvs_q, dvs_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic                qneg_q, qneg_d;
    logic                rneg_q, rneg_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;
`ifdef DIV_DBZ_FLAG_EN
    logic                dbz_seen_q, dbz_seen_d;
    logic                dbz_q, dbz_d;
`endif

    logic [DATA_W:0]     shifted;
    logic [DATA_W:0]     trial;
    logic                borrow;
    logic [DATA_W-1:0]   abs1, abs2;
    logic [DATA_W-1:0]   q_fin, r_fin;

    // The partial remainder is always below the divisor, so when the shifted
    // value overflows DATA_W bits the difference still fits and its MSB is 0:
    // the extra MSB of the DATA_W+1 bit trial is exactly the borrow.
    assign shifted = {rem_q, dvd_q[DATA_W-1]};
    assign trial   = shifted - {1'b0, dvs_q};
    assign borrow  = trial[DATA_W];

    assign abs1  = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign abs2  = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    assign q_fin = qneg_q ? -dvd_q : dvd_q;
    assign r_fin = rneg_q ? -rem_q : rem_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        ready_d  = ready_q;
`ifdef DIV_DBZ_FLAG_EN
        dbz_seen_d = dbz_seen_q;
        dbz_d      = dbz_q;
`endif
        case (state_q)
            S_FREE: begin
                result_d = '0;
                ready_d  = 1'b0;
`ifdef DIV_DBZ_FLAG_EN
                dbz_d    = 1'b0;
`endif
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = S_BYZERO;
`ifdef DIV_DBZ_FLAG_EN
                        dbz_seen_d = 1'b1;
`endif
                    end else begin
                        state_d = S_ON;
                        dvd_d   = abs1;
                        dvs_d   = abs2;
                        rem_d   = '0;
                        cnt_d   = '0;
                        qneg_d  = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        rneg_d  = signed_div_i & opdata1_i[DATA_W-1];
`ifdef DIV_DBZ_FLAG_EN
                        dbz_seen_d = 1'b0;
`endif
                    end
                end
            end
            S_BYZERO: begin
                if (annul_i) begin
                    state_d = S_FREE;
                end else begin
                    state_d = S_END;
                    dvd_d   = '0;
                    rem_d   = '0;
                    qneg_d  = 1'b0;
                    rneg_d  = 1'b0;
                end
            end
            S_ON: begin
                if (annul_i) begin
                    state_d = S_FREE;
                end else begin
                    rem_d = borrow ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
                    dvd_d = {dvd_q[DATA_W-2:0], ~borrow};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = S_END;
                    end
                end
            end
            S_END: begin
                if (!start_i) begin
                    state_d  = S_FREE;
                    ready_d  = 1'b0;
                    result_d = '0;
`ifdef DIV_DBZ_FLAG_EN
                    dbz_d    = 1'b0;
`endif
                end else begin
                    ready_d  = 1'b1;
                    result_d = {r_fin, q_fin};
`ifdef DIV_DBZ_FLAG_EN
                    dbz_d    = dbz_seen_q;
`endif
                end
            end
            default: state_d = S_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FREE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
`ifdef DIV_DBZ_FLAG_EN
            dbz_seen_q <= 1'b0;
            dbz_q      <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            ready_q  <= ready_d;
`ifdef DIV_DBZ_FLAG_EN
            dbz_seen_q <= dbz_seen_d;
            dbz_q      <= dbz_d;
`endif
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
`ifdef DIV_DBZ_FLAG_EN
    assign div_by_zero_o = dbz_q;
`endif

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signed/unsigned results,
// divide-by-zero, annul, mid-division reset and operand stability.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1, op2;
    logic        start, annul;
    logic [63:0] result_o;
    logic        ready_o;
`ifdef DIV_DBZ_FLAG_EN
    logic        dbz_o;
`endif

    int n_total = 0;
    int n_pass  = 0;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result_o),
        .ready_o      (ready_o)
`ifdef DIV_DBZ_FLAG_EN
        ,
        .div_by_zero_o(dbz_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Counts posedges from now until ready_o is seen high (100 = timed out).
    task automatic wait_ready(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (ready_o === 1'b1) break;
        end
    endtask

    // Watches n edges and reports whether ready_o was ever high.
    task automatic watch_ready(input int n, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (ready_o !== 1'b0) seen = 1'b1;
        end
    endtask

    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp_res,
                           input int exp_lat, input logic exp_dbz);
        int lat;
        @(negedge clk);
        signed_div = sgn;
        op1        = a;
        op2        = b;
        start      = 1'b1;
        @(posedge clk);
        wait_ready(lat);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_res"}, result_o, exp_res);
`ifdef DIV_DBZ_FLAG_EN
        chk({tag, "_dbz"}, {63'd0, dbz_o}, {63'd0, exp_dbz});
`else
        if (exp_dbz) begin
            chk({tag, "_dbz_res"}, result_o, 64'd0);
        end
`endif
        @(posedge clk);
        #1;
        chk({tag, "_hold"}, {ready_o, result_o[62:0]}, {1'b1, exp_res[62:0]});
        start = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_drop"}, {63'd0, ready_o} | result_o, 64'd0);
    endtask

    initial begin
        int   lat;
        logic seen;

        rst = 1'b1; signed_div = 1'b0; op1 = '0; op2 = '0; start = 1'b0; annul = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", {63'd0, ready_o}, 64'd0);
        chk("reset_result", result_o, 64'd0);
        rst = 1'b0;

        run_div("u100_7",   1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                 33, 1'b0);
        run_div("s_m7_2",   1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD},  33, 1'b0);
        run_div("s_7_m2",   1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1, 32'hFFFF_FFFD},          33, 1'b0);
        run_div("u_fff9_2", 1'b0, 32'hFFFF_FFF9,  32'd2,          {32'd1, 32'h7FFF_FFFC},          33, 1'b0);
        run_div("u_max_1",  1'b0, 32'hFFFF_FFFF,  32'd1,          {32'd0, 32'hFFFF_FFFF},          33, 1'b0);
        run_div("u_max_m1", 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  {32'd1, 32'd1},                  33, 1'b0);
        run_div("s_ovf",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0, 32'h8000_0000},          33, 1'b0);
        run_div("dbz",      1'b0, 32'h1234_5678,  32'd0,          64'd0,                            2, 1'b1);

        // annul in the middle of 50/5
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd50; op2 = 32'd5; start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul = 1'b1; start = 1'b0;
        @(posedge clk);
        #1;
        chk("annul_out", {63'd0, ready_o} | result_o, 64'd0);
        annul = 1'b0;
        watch_ready(40, seen);
        chk("annul_never_ready", {63'd0, seen}, 64'd0);
        run_div("after_annul_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 1'b0);

        // start together with annul in FREE must not be accepted
        @(negedge clk);
        op1 = 32'd100; op2 = 32'd7; start = 1'b1; annul = 1'b1;
        watch_ready(40, seen);
        chk("annul_free_ignored", {63'd0, seen}, 64'd0);
        @(negedge clk);
        start = 1'b0; annul = 1'b0;

        // reset at iteration 20
        @(negedge clk);
        op1 = 32'd50; op2 = 32'd5; start = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_out", {63'd0, ready_o} | result_o, 64'd0);
        rst = 1'b0; start = 1'b0;
        run_div("after_rst_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b0);

        // operand change during ON is ignored
        @(negedge clk);
        op1 = 32'd50; op2 = 32'd5; start = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        op1 = 32'd9; op2 = 32'd4;
        wait_ready(lat);
        chk("opchg_lat", 64'(lat + 5), 64'd33);
        chk("opchg_res", result_o, {32'd0, 32'd10});
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("opchg_drop", {63'd0, ready_o} | result_o, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
